// File: rtl/display_scan_ctrl_if.sv
// Bus between the clock interface and the display scan controller:
// digit codes and blink controls in, anode/cathode drive and frame strobe out.
interface display_scan_ctrl_if;
    logic [5:0] d1;
    logic [5:0] d2;
    logic [5:0] d3;
    logic [5:0] d4;
    logic [5:0] d5;
    logic [5:0] d6;
    logic [5:0] d7;
    logic [5:0] d8;
    logic [7:0] blink_mask;
    logic       blink_tick;
    logic [7:0] an;
    logic [7:0] dec_cat;
    logic       frame_start;

    modport master (
        output d1, d2, d3, d4, d5, d6, d7, d8, blink_mask, blink_tick,
        input  an, dec_cat, frame_start
    );

    modport slave (
        input  d1, d2, d3, d4, d5, d6, d7, d8, blink_mask, blink_tick,
        output an, dec_cat, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan controller: one digit per slot, a blank
// gap at the start of each slot, and blinking of selected digits.
module display_scan_ctrl #(
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input logic                clock,
    input logic                reset,
    display_scan_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [0:0]       state;
    logic             phase;
    logic [7:0]       an_q;
    logic [7:0]       cat_q;
    logic             fs_q;

    logic [5:0]       d_sel;
    logic             mask_sel;
    logic [6:0]       seg_sel;
    logic [7:0]       an_next;

    // Select the code and blink bit of the digit owning the current slot.
    always_comb begin
        d_sel = '0;
        case (idx)
            3'd0: d_sel = bus.d1;
            3'd1: d_sel = bus.d2;
            3'd2: d_sel = bus.d3;
            3'd3: d_sel = bus.d4;
            3'd4: d_sel = bus.d5;
            3'd5: d_sel = bus.d6;
            3'd6: d_sel = bus.d7;
            default: d_sel = bus.d8;
        endcase
        mask_sel = bus.blink_mask[idx];
        an_next  = (d_sel[5] && !(mask_sel && phase)) ? ~(8'b1 << idx) : 8'hFF;
    end

    // Hex to active-low segments a..g (bit0 = a).
    always_comb begin
        seg_sel = 7'h7F;
        case (d_sel[4:1])
            4'h0: seg_sel = 7'h40;
            4'h1: seg_sel = 7'h79;
            4'h2: seg_sel = 7'h24;
            4'h3: seg_sel = 7'h30;
            4'h4: seg_sel = 7'h19;
            4'h5: seg_sel = 7'h12;
            4'h6: seg_sel = 7'h02;
            4'h7: seg_sel = 7'h78;
            4'h8: seg_sel = 7'h00;
            4'h9: seg_sel = 7'h10;
            4'hA: seg_sel = 7'h08;
            4'hB: seg_sel = 7'h03;
            4'hC: seg_sel = 7'h46;
            4'hD: seg_sel = 7'h21;
            4'hE: seg_sel = 7'h06;
            default: seg_sel = 7'h0E;
        endcase
    end

    // Slot cycle counter and digit index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // BLANK/ON sequencing; the output registers double as the latched digit,
    // so they hold steady for the whole ON period regardless of input changes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_BLANK;
            an_q  <= '1;
            cat_q <= '1;
        end else if (cnt == CNT_LAST) begin
            state <= ST_BLANK;
            an_q  <= '1;
            cat_q <= '1;
        end else if (state == ST_BLANK && cnt == CNT_LATCH) begin
            state <= ST_ON;
            an_q  <= an_next;
            cat_q <= {~d_sel[0], seg_sel};
        end
    end

    // Blink phase; the latch above sees the pre-toggle value on a shared edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= 1'b0;
        end else if (bus.blink_tick) begin
            phase <= ~phase;
        end
    end

    // One-cycle strobe on the slot 7 to slot 0 wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fs_q <= 1'b0;
        end else begin
            fs_q <= (cnt == CNT_LAST) && (idx == 3'd7);
        end
    end

    assign bus.an          = an_q;
    assign bus.dec_cat     = cat_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SLOT_CYCLES=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   e;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .SLOT_CYCLES (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] seg(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
            12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after rising edge t (edges counted from reset release).
    task automatic adv_to(input int t);
        while (e < t) begin
            @(posedge clock);
            e++;
        end
        #1;
    endtask

    task automatic scan_check(input int k, input int last_edge);
        int slot;
        int c;
        logic [7:0] exp_an;
        logic [7:0] exp_cat;
        slot    = (k / 8) % 8;
        c       = k % 8;
        exp_an  = (c >= 2) ? ~(8'h01 << slot) : 8'hFF;
        exp_cat = (c >= 2) ? seg(slot) : 8'hFF;
        check($sformatf("an_e%0d", k), bus.an, exp_an);
        check($sformatf("cat_e%0d", k), bus.dec_cat, exp_cat);
        check($sformatf("fs_e%0d", k), {7'b0, bus.frame_start},
              (k == 64 && last_edge >= 64) ? 8'h01 : 8'h00);
    endtask

    initial begin
        int base;
        logic [3:0] vv;
        checks   = 0;
        failures = 0;
        e        = 0;
        reset    = 1'b0;
        bus.d1 = {1'b1, 4'd0, 1'b0};
        bus.d2 = {1'b1, 4'd1, 1'b0};
        bus.d3 = {1'b1, 4'd2, 1'b0};
        bus.d4 = {1'b1, 4'd3, 1'b0};
        bus.d5 = {1'b1, 4'd4, 1'b0};
        bus.d6 = {1'b1, 4'd5, 1'b0};
        bus.d7 = {1'b1, 4'd6, 1'b0};
        bus.d8 = {1'b1, 4'd7, 1'b0};
        bus.blink_mask = 8'h00;
        bus.blink_tick = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_an", bus.an, 8'hFF);
        check("rst_cat", bus.dec_cat, 8'hFF);
        check("rst_fs", {7'b0, bus.frame_start}, 8'h00);

        // Basic scan over one frame plus one slot
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            adv_to(k);
            scan_check(k, 72);
        end

        // All 16 hex values on d1 with alternating dp
        for (int v = 0; v < 16; v++) begin
            base = 64 * (2 + v);
            vv   = 4'(v);
            adv_to(base + 1);
            bus.d1 = {1'b1, vv, vv[0]};
            adv_to(base + 4);
            check($sformatf("hex_an_%0d", v), bus.an, 8'hFE);
            check($sformatf("hex_cat_%0d", v), bus.dec_cat, seg(v) & (vv[0] ? 8'h7F : 8'hFF));
        end

        // Disabled digit index 1: dark for the whole slot, scan keeps going
        base = 64 * 18;
        adv_to(base + 1);
        bus.d2 = {1'b0, 4'd5, 1'b0};
        for (int k = 8; k <= 15; k++) begin
            adv_to(base + k);
            check($sformatf("dis_an_%0d", k), bus.an, 8'hFF);
            if (k == 10) check("dis_cat", bus.dec_cat, 8'h92);
        end
        adv_to(base + 18);
        check("dis_next_an", bus.an, 8'hFB);
        bus.d2 = {1'b1, 4'd1, 1'b0};

        // Blink mask 0x05 with one tick after the slot-0 latch
        base = 64 * 19;
        adv_to(base + 1);
        bus.blink_mask = 8'h05;
        adv_to(base + 2);
        bus.blink_tick = 1'b1;
        adv_to(base + 3);
        bus.blink_tick = 1'b0;
        adv_to(base + 4);  check("blk_s0_pre", bus.an, 8'hFE);
        adv_to(base + 10); check("blk_s1", bus.an, 8'hFD);
        adv_to(base + 18); check("blk_s2", bus.an, 8'hFF);
        adv_to(base + 26); check("blk_s3", bus.an, 8'hF7);
        adv_to(base + 34); check("blk_s4", bus.an, 8'hEF);
        base = 64 * 20;
        adv_to(base + 4);  check("blk_s0", bus.an, 8'hFF);
        adv_to(base + 10); check("blk_s1b", bus.an, 8'hFD);
        adv_to(base + 18); check("blk_s2b", bus.an, 8'hFF);
        adv_to(base + 20);
        bus.blink_tick = 1'b1;
        adv_to(base + 21);
        bus.blink_tick = 1'b0;
        base = 64 * 21;
        adv_to(base + 4);  check("unblk_s0", bus.an, 8'hFE);
        adv_to(base + 18); check("unblk_s2", bus.an, 8'hFB);

        // Mid-slot change and tick on the latch edge
        adv_to(base + 20);
        bus.d1 = {1'b1, 4'd3, 1'b0};
        bus.blink_mask = 8'h03;
        base = 64 * 22;
        adv_to(base + 1);
        bus.blink_tick = 1'b1;
        adv_to(base + 2);
        bus.blink_tick = 1'b0;
        check("mid_an", bus.an, 8'hFE);
        check("mid_cat", bus.dec_cat, 8'hB0);
        adv_to(base + 4);
        bus.d1 = {1'b1, 4'd8, 1'b0};
        adv_to(base + 5); check("mid_cat5", bus.dec_cat, 8'hB0);
        adv_to(base + 7); check("mid_cat7", bus.dec_cat, 8'hB0);
        check("mid_an7", bus.an, 8'hFE);
        adv_to(base + 10);
        check("defer_s1_an", bus.an, 8'hFF);
        check("defer_s1_cat", bus.dec_cat, 8'hF9);
        base = 64 * 23;
        adv_to(base + 2);
        check("next_s0_an", bus.an, 8'hFF);
        check("next_s0_cat", bus.dec_cat, 8'h80);
        bus.blink_tick = 1'b1;
        adv_to(base + 3);
        bus.blink_tick = 1'b0;
        bus.blink_mask = 8'h00;
        bus.d1 = {1'b1, 4'd0, 1'b0};

        // Asynchronous reset at cnt=5 of slot 3
        base = 64 * 24;
        adv_to(base + 29);
        check("pre_rst_an", bus.an, 8'hF7);
        check("pre_rst_cat", bus.dec_cat, 8'hB0);
        #1;
        reset = 1'b0;
        #1;
        check("async_an", bus.an, 8'hFF);
        check("async_cat", bus.dec_cat, 8'hFF);
        check("async_fs", {7'b0, bus.frame_start}, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        e = 0;
        for (int k = 1; k <= 16; k++) begin
            adv_to(k);
            scan_check(k, 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the eight-digit seven-segment display on the digital clock board. It sits between the clock interface, which produces the eight 6-bit digit codes d1..d8, and the board's shared cathode/anode pins. It schedules one digit at a time on the common segment bus, inserts anti-ghosting blank gaps between digits, and blanks selected digits in a blink pattern so the field being edited in a set mode flashes.

## Interface
- SLOT_CYCLES, 100000: clock cycles per digit slot; 1 kHz per digit at 100 MHz. Must be at least BLANK_CYCLES+1.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be at least 1.
- clock  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low
- d1..d8  in  6 each  digit codes: bit5 = enable, bits4:1 = hex value, bit0 = decimal point. d1 is the rightmost digit, index 0.
- blink_mask  in  8  bit i = 1 marks digit index i as blinking
- blink_tick  in  1  single-cycle pulse that toggles the blink phase; normally driven by pulse_1hz
- an  out  8  anodes, active-low; an[i] drives digit index i
- dec_cat  out  8  cathodes, active-low; bit0..6 = segments a..g, bit7 = dp
- frame_start  out  1  one-cycle pulse at the start of slot 0 of each frame

## Operation
- Counters:
  - cnt runs 0..SLOT_CYCLES-1 and wraps.
  - idx runs 0..7 and increments when cnt wraps. idx wraps 7→0.
- Two-state FSM, BLANK and ON:
  - BLANK → ON at the edge where cnt goes BLANK_CYCLES-1 → BLANK_CYCLES.
  - ON → BLANK at the edge where cnt wraps to 0.
- On the BLANK→ON edge, the block latches the code for digit idx, blink_mask[idx] and the current blink phase. Input changes during ON have no effect until the next slot.
- During ON:
  - an is one-hot low at bit idx. If the latched enable is 0, or the latched blink bit and blink phase are both 1, an stays 0xFF.
  - dec_cat = hex decode of the latched bits4:1. dp is on (bit7 low) when latched bit0 = 1.
- During BLANK: an = 0xFF and dec_cat = 0xFF.
- Hex decode, with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- blink phase: reset value 0. Toggles on every cycle with blink_tick = 1. A tick arriving on the same edge as the latch is applied after the latch, so it takes effect from the next slot.
- frame_start is high for one cycle, registered, on the edge where idx becomes 0 and cnt becomes 0, i.e. the 7→0 slot wrap. It is not asserted at reset release.
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Reset values: cnt = 0, idx = 0, FSM = BLANK, blink phase = 0, an = 0xFF, dec_cat = 0xFF, frame_start = 0.
- Edge 1 is the first rising edge with reset high.
- Slot 0:
  - an/dec_cat become active at edge BLANK_CYCLES, driving idx 0.
  - They return to 0xFF at edge SLOT_CYCLES, which starts slot 1.
- Per slot: exactly BLANK_CYCLES cycles blank, then exactly SLOT_CYCLES-BLANK_CYCLES cycles active.
- Frame period: 8·SLOT_CYCLES cycles. The first frame_start occurs at edge 8·SLOT_CYCLES.
- Latency from a d-input change to the display is at most SLOT_CYCLES·8 + BLANK_CYCLES cycles.
- Reset asserted mid-slot: an = 0xFF and dec_cat = 0xFF immediately, with no clock needed. Scanning restarts from slot 0 on release.

## Test plan
- Bench parameters: SLOT_CYCLES=8, BLANK_CYCLES=2.
- Reset release, d1..d8 = {1,value i,0}, blink_mask=0:
  - an = FE at edges 2–7, FF at edges 8–9, FD from edge 10, …, 7F in slot 7.
  - dec_cat in slot 0 = C0 (value 0), slot 1 = F9 (value 1), …
  - frame_start high only in the cycle after edge 64.
- All 16 hex values on d1 with the dp bit alternating: dec_cat matches the decode list, with bit7 cleared when dp = 1. An enable=0 digit gives an = FF for its whole slot while cnt and idx keep advancing.
- blink_mask = 0x05, with one blink_tick pulse:
  - Slots 0 and 2 are dark for every slot latched after the tick.
  - All other digits are unaffected.
  - A second tick restores slots 0 and 2.
- Mid-slot input change: change d1 from value 3 to value 8 at cnt = 4 of slot 0. dec_cat stays B0 through the slot and shows 80 in slot 0 of the next frame. Also assert blink_tick exactly at the latch edge and check it is deferred by one slot.
- Assert reset at cnt = 5 of slot 3: an/dec_cat go to FF asynchronously, before the next edge. After release, the slot-0 timing is identical to the first scenario.
